// File: rtl/fp_add_abs_cvt_unit.sv
// Single-precision FADD/FSUB/FABS/FCVT.S.W slice, fixed 3-cycle latency, one issue per clock.
// Optional FPU_FSUB_EN: op 01 performs FSUB; without it op 01 decodes as FADD.
module fp_add_abs_cvt_unit #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        out_valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        OP_FADD   = 2'b00,
        OP_FSUB   = 2'b01,
        OP_FABS   = 2'b10,
        OP_FCVTSW = 2'b11
    } op_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int unsigned i = 0; i < 32; i++)
            if (v[i]) n = 6'(31 - i);
        return n;
    endfunction

    logic [LATENCY-1:0] stage_vld;
    op_e                i_op;
    logic [31:0]        i_a, i_b;
    logic [31:0]        s3_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            stage_vld <= {stage_vld[LATENCY-2:0], in_valid};
            out_valid <= stage_vld[LATENCY-1];
            if (stage_vld[LATENCY-1]) result <= s3_result;
        end
    end

    always_ff @(posedge clk) begin
        i_op <= op_e'(op);
        i_a  <= src_a;
        i_b  <= src_b;
    end

    // ---------------- S1: unpack, compare/swap, int abs ----------------
    logic        b_sign_eff;
    logic [7:0]  a_exp, b_exp, exp_diff;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [30:0] a_mag, b_mag;
    logic [23:0] a_mant, b_mant;

    logic        n1_special, n1_is_cvt, n1_sign, n1_sub;
    logic [31:0] n1_special_val, n1_int_abs;
    logic [7:0]  n1_exp_big;
    logic [23:0] n1_mant_big, n1_mant_small;
    logic [4:0]  n1_shift;

    always_comb begin
`ifdef FPU_FSUB_EN
        b_sign_eff = i_b[31] ^ (i_op == OP_FSUB);
`else
        b_sign_eff = i_b[31];
`endif
    end

    always_comb begin
        a_exp  = i_a[30:23];
        b_exp  = i_b[30:23];
        a_frac = i_a[22:0];
        b_frac = i_b[22:0];
        a_zero = (a_exp == 8'h00);
        b_zero = (b_exp == 8'h00);
        a_inf  = (a_exp == 8'hFF) && (a_frac == 23'h0);
        b_inf  = (b_exp == 8'hFF) && (b_frac == 23'h0);
        a_nan  = (a_exp == 8'hFF) && (a_frac != 23'h0);
        b_nan  = (b_exp == 8'hFF) && (b_frac != 23'h0);
        // denormals compare and add as zero
        a_mag  = {a_exp, a_zero ? 23'h0 : a_frac};
        b_mag  = {b_exp, b_zero ? 23'h0 : b_frac};
        a_mant = a_zero ? 24'h0 : {1'b1, a_frac};
        b_mant = b_zero ? 24'h0 : {1'b1, b_frac};
        a_big  = (a_mag >= b_mag);

        n1_is_cvt     = (i_op == OP_FCVTSW);
        n1_int_abs    = i_a[31] ? (~i_a + 32'd1) : i_a;
        n1_sub        = i_a[31] ^ b_sign_eff;
        n1_exp_big    = a_big ? a_exp : b_exp;
        n1_mant_big   = a_big ? a_mant : b_mant;
        n1_mant_small = a_big ? b_mant : a_mant;
        exp_diff      = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
        n1_shift      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        n1_sign       = n1_is_cvt ? i_a[31] : (a_big ? i_a[31] : b_sign_eff);

        n1_special     = 1'b0;
        n1_special_val = '0;
        case (i_op)
            OP_FABS: begin
                n1_special     = 1'b1;
                n1_special_val = {1'b0, i_a[30:0]};
            end
            OP_FCVTSW: ;
            default: begin
                if (a_nan || b_nan || (a_inf && b_inf && n1_sub)) begin
                    n1_special     = 1'b1;
                    n1_special_val = CANON_NAN;
                end else if (a_inf) begin
                    n1_special     = 1'b1;
                    n1_special_val = {i_a[31], 8'hFF, 23'h0};
                end else if (b_inf) begin
                    n1_special     = 1'b1;
                    n1_special_val = {b_sign_eff, 8'hFF, 23'h0};
                end else if (a_zero && b_zero) begin
                    n1_special     = 1'b1;
                    n1_special_val = {i_a[31] & b_sign_eff, 31'h0};
                end
            end
        endcase
    end

    logic        s1_special, s1_is_cvt, s1_sign, s1_sub;
    logic [31:0] s1_special_val, s1_int_abs;
    logic [7:0]  s1_exp_big;
    logic [23:0] s1_mant_big, s1_mant_small;
    logic [4:0]  s1_shift;

    always_ff @(posedge clk) begin
        s1_special     <= n1_special;
        s1_special_val <= n1_special_val;
        s1_is_cvt      <= n1_is_cvt;
        s1_sign        <= n1_sign;
        s1_sub         <= n1_sub;
        s1_int_abs     <= n1_int_abs;
        s1_exp_big     <= n1_exp_big;
        s1_mant_big    <= n1_mant_big;
        s1_mant_small  <= n1_mant_small;
        s1_shift       <= n1_shift;
    end

    // ---------------- S2: align with sticky, add/sub, LZC ----------------
    logic [26:0] big27, small27, small_sh, aligned;
    logic [27:0] sum28;
    logic [31:0] n2_mag;
    logic [9:0]  n2_exp_base;
    logic [5:0]  n2_lzc;

    always_comb begin
        big27    = {s1_mant_big, 3'b000};
        small27  = {s1_mant_small, 3'b000};
        small_sh = small27 >> s1_shift;
        aligned  = {small_sh[26:1], small_sh[0] | ((small_sh << s1_shift) != small27)};
        sum28    = s1_sub ? ({1'b0, big27} - {1'b0, aligned})
                          : ({1'b0, big27} + {1'b0, aligned});
        // Both paths share one normaliser: magnitude MSB at bit 31 has exponent exp_base.
        n2_mag      = s1_is_cvt ? s1_int_abs : {sum28, 4'h0};
        n2_exp_base = s1_is_cvt ? 10'd158 : ({2'b00, s1_exp_big} + 10'd1);
        n2_lzc      = lzc32(n2_mag);
    end

    logic        s2_special, s2_sign;
    logic [31:0] s2_special_val, s2_mag;
    logic [9:0]  s2_exp_base;
    logic [5:0]  s2_lzc;

    always_ff @(posedge clk) begin
        s2_special     <= s1_special;
        s2_special_val <= s1_special_val;
        s2_sign        <= s1_sign;
        s2_mag         <= n2_mag;
        s2_exp_base    <= n2_exp_base;
        s2_lzc         <= n2_lzc;
    end

    // ---------------- S3: normalise, RNE, pack ----------------
    logic [31:0]        norm;
    logic [23:0]        mant;
    logic               g_bit, r_bit, s_bit, round_up;
    logic [24:0]        mant_r;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac_r;

    always_comb begin
        norm     = s2_mag << s2_lzc[4:0];
        mant     = norm[31:8];
        g_bit    = norm[7];
        r_bit    = norm[6];
        s_bit    = |norm[5:0];
        round_up = g_bit & (r_bit | s_bit | mant[0]);
        mant_r   = {1'b0, mant} + 25'(round_up);
        exp_r    = s2_exp_base - {4'b0000, s2_lzc} + {9'h000, mant_r[24]};
        frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        if (s2_special)
            s3_result = s2_special_val;
        else if (s2_lzc[5])
            s3_result = '0;
        else if (exp_r <= 10'sd0)
            s3_result = '0;
        else if (exp_r >= 10'sd255)
            s3_result = {s2_sign, 8'hFF, 23'h0};
        else
            s3_result = {s2_sign, exp_r[7:0], frac_r};
    end

endmodule

// File: tb/tb_fp_add_abs_cvt_unit.sv
// Self-checking bench for fp_add_abs_cvt_unit: directed vectors plus randomized traffic
// checked against a real-arithmetic reference model and a timestamped expectation queue.
module tb_fp_add_abs_cvt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        out_valid;
    logic [31:0] result;

    fp_add_abs_cvt_unit #(.LATENCY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, expv);
    endtask

    // ---- reference model: exact-enough double arithmetic, then RNE to single ----
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00) d = {f[31], 63'h0};
        else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] hi;
        logic [28:0] rem;
        int          be;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        hi  = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && hi[0])) hi = hi + 25'd1;
        be = int'(d[62:52]) - 896;
        if (hi[24]) begin
            be++;
            hi = hi >> 1;
        end
        if (be <= 0) return 32'h0;
        if (be >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], 8'(be), hi[22:0]};
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        if (o == 2'b10) return {1'b0, a[30:0]};
        if (o == 2'b11) return r2f($itor($signed(a)));
`ifdef FPU_FSUB_EN
        if (o == 2'b01) b[31] = ~b[31];
`endif
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    // ---- expectation queue keyed by the edge count at which the result appears ----
    typedef struct {
        int unsigned due;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int unsigned edges    = 0;
    logic [31:0] last_res = 32'h0;

    task automatic step(input logic v, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic r, input logic [31:0] expv);
        exp_t e;
        in_valid = v;
        op       = o;
        src_a    = a;
        src_b    = b;
        rst      = r;
        if (r) begin
            q.delete();
            last_res = 32'h0;
        end else if (v) begin
            e.due = edges + 4;
            e.op  = o;
            e.a   = a;
            e.b   = b;
            e.val = expv;
            q.push_back(e);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (q.size() != 0 && q[0].due == edges) begin
            e = q.pop_front();
            chk($sformatf("out_valid op%0d", e.op), {31'h0, out_valid}, 32'h1);
            chk($sformatf("result op%0d a=%08h b=%08h", e.op, e.a, e.b), result, e.val);
            last_res = e.val;
        end else begin
            chk("out_valid_idle", {31'h0, out_valid}, 32'h0);
            chk("result_hold", result, last_res);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
        step(1'b1, o, a, b, 1'b0, expv);
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_operand(input logic [1:0] o, input logic [31:0] other);
        logic [31:0] x;
        int unsigned mode;
        mode = $urandom_range(0, 5);
        x = $urandom;
        case (mode)
            0: x = x;
            1: x = {x[31], 8'(126 + $urandom_range(0, 4)), x[22:0]};
            2: x = {~other[31], other[30:0] + 31'($urandom_range(0, 3))};
            3: x = {other[31] ^ x[31], other[30:23] - 8'($urandom_range(0, 30)), x[22:0]};
            4: case ($urandom_range(0, 5))
                   0: x = 32'h7F80_0000;
                   1: x = 32'hFF80_0000;
                   2: x = 32'h7FA0_0001;
                   3: x = {x[31], 8'h00, x[22:0]};
                   4: x = {x[31], 31'h0};
                   default: x = {x[31], 8'hFE, x[22:0]};
               endcase
            default: x = (o == 2'b11) ? 32'($signed($urandom_range(0, 70000)) - 35000) : x;
        endcase
        return x;
    endfunction

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int unsigned r;

        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
        idle(1);

        // directed vectors, issued back to back
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        issue(2'b00, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
`ifdef FPU_FSUB_EN
        issue(2'b01, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
`else
        issue(2'b01, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000);
`endif
        issue(2'b10, 32'hC049_0FDB, 32'h1234_5678, 32'h4049_0FDB);
        issue(2'b10, 32'h7FC0_0001, 32'h0, 32'h7FC0_0001);
        issue(2'b11, 32'hFFFF_FFFF, 32'h0, 32'hBF80_0000);
        issue(2'b11, 32'h0100_0001, 32'h0, 32'h4B80_0000);
        issue(2'b11, 32'h8000_0000, 32'h0, 32'hCF00_0000);
        issue(2'b11, 32'h0000_0000, 32'h0, 32'h0000_0000);
        issue(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        issue(2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        issue(2'b00, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        issue(2'b00, 32'h007F_FFFF, 32'h3F80_0000, 32'h3F80_0000);
        issue(2'b00, 32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
        issue(2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        issue(2'b00, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        issue(2'b00, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
        issue(2'b00, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
        idle(4);

        // three consecutive issues, then the same with a reset after the second
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        issue(2'b10, 32'hC049_0FDB, 32'h0, 32'h4049_0FDB);
        issue(2'b11, 32'hFFFF_FFFF, 32'h0, 32'hBF80_0000);
        idle(4);
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        issue(2'b10, 32'hC049_0FDB, 32'h0, 32'h4049_0FDB);
        step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0);
        idle(5);

        // randomized traffic with bubbles and occasional reset
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            o = 2'($urandom_range(0, 3));
            a = rand_operand(o, $urandom);
            b = rand_operand(o, a);
            if (r < 2) step(1'b1, o, a, b, 1'b1, 32'h0);
            else if (r < 80) issue(o, a, b, model(o, a, b));
            else idle(1);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_add_abs_cvt_unit.md
Name: fp_add_abs_cvt_unit

Overview:
- Single-precision FP execution slice for the core's FPU.
- Performs FADD, FABS and FCVT.S.W (signed int32 to float), plus FSUB when the optional feature is enabled.
- Fully pipelined with a fixed 3-cycle latency for every op and one issue per cycle.
- No backpressure. The FPU controller stalls the core against the constant latency.

Parameters:
- LATENCY, 3, pipeline depth in clocks from issue to result. Fixed; the only supported value is 3.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  issue strobe; operands and op are sampled on the clk edge where it is 1.
- op  in  2  operation: 00 FADD, 01 FSUB, 10 FABS, 11 FCVTSW.
- src_a  in  32  operand A: float, or int32 for FCVTSW.
- src_b  in  32  operand B: float; ignored for FABS and FCVTSW.
- out_valid  out  1  result strobe.
- result  out  32  IEEE-754 single result.

Behaviour:
- Reset:
  - Synchronous, on any clk edge with rst=1.
  - Clears all stage valid bits, out_valid=0 and result=32'h0.
  - In-flight ops are discarded, including any issued in the same cycle as reset.
- Latency and throughput:
  - An op issued at edge N produces out_valid=1 with its result after edge N+3.
  - Ops complete in issue order. Back-to-back issue is allowed every cycle.
- When out_valid=0, result holds its last value (0 after reset).
- Stages:
  - S1: unpack; exponent compare and swap; int abs and sign for CVTSW.
  - S2: align shift with sticky, add or subtract magnitudes; leading-zero count.
  - S3: normalize, round-to-nearest-even, pack; drive output registers.
- FABS: result = {1'b0, src_a[30:0]}. Bit-exact passthrough, including NaN and denormal payloads; only the latency is applied.
- FADD/FSUB:
  - FSUB uses the FADD path with src_b[31] inverted.
  - Denormal inputs (exp=0) are treated as signed zero. Denormal or underflowing results are flushed to +0.
  - Exact cancellation (x + -x) gives +0 (32'h00000000). (-0) + (-0) gives 32'h80000000.
  - Overflow after rounding gives a signed infinity (exp=8'hFF, frac=0).
  - Rounding is RNE using guard, round and sticky bits, with mantissa carry-out incrementing the exponent.
- Special inputs:
  - If either input is NaN, or the op is inf + (-inf), the result is canonical NaN 32'h7FC00000.
  - Otherwise an infinite input yields that infinity with its sign.
- FCVTSW:
  - src_a is signed two's complement; 0 gives 32'h00000000.
  - Magnitudes above 2^24 are rounded RNE.
  - -2^31 gives 32'hCF000000.
- op and operands are don't-care when in_valid=0. Idle cycles create bubbles: out_valid=0 three cycles later.

Optional Feature:
- Macro: FPU_FSUB_EN.
- Defined: op 01 performs src_a - src_b as described above.
- Undefined:
  - op 01 is decoded as FADD.
  - The sign-inversion mux is removed.

Test Plan:
- FADD 32'h3F800000 + 32'h40000000 issued at edge 0 -> out_valid=1 after edge 3, result 32'h40400000. FADD 32'h3F800000 + 32'hBF800000 -> 32'h00000000.
- FSUB (FPU_FSUB_EN) 32'h40400000 - 32'h3F800000 -> 32'h40000000. Without the macro, the same op=01 stimulus -> 32'h40800000.
- FABS 32'hC0490FDB -> 32'h40490FDB. FABS 32'h7FC00001 -> 32'h7FC00001.
- FCVTSW:
  - 32'hFFFFFFFF -> 32'hBF800000.
  - 32'h01000001 -> 32'h4B800000 (tie to even).
  - 32'h80000000 -> 32'hCF000000.
- FADD 32'h7F7FFFFF + 32'h7F7FFFFF -> 32'h7F800000. FADD 32'h7F800000 + 32'hFF800000 -> 32'h7FC00000.
- Pipeline and reset:
  - Issue FADD, FABS, FCVTSW on 3 consecutive edges -> 3 consecutive out_valid pulses in order with correct results.
  - Repeat, but assert rst for one edge after the second issue -> no out_valid pulses, result=0.
